// File: rtl/tap_fastload.sv
// Oric .TAP fast loader: parses one block from the tape cache and writes its payload into RAM.
// Optional TAP_FASTLOAD_BASIC_PTR_EN adds zero-page BASIC pointer writes after a BASIC payload.
module tap_fastload #(
  parameter int NAME_MAX = 16,
  parameter int MIN_SYNC = 3
) (
  input  logic        clk_48,
  input  logic        reset,
  input  logic        start,
  input  logic [24:0] tape_end,
  output logic [24:0] cache_addr,
  output logic        cache_rd,
  input  logic [7:0]  cache_data,
  output logic [15:0] tape_addr,
  output logic        tape_wr,
  output logic [7:0]  tape_dout,
  output logic [15:0] loadpoint,
  output logic        tape_autorun,
  output logic        tape_complete,
  output logic        busy,
  output logic        error
);

  // MARK is kept for state-encoding compatibility; the 0x24 mark is consumed inside SYNC.
  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_MARK, S_HEADER, S_NAME, S_DATA, S_PTRS, S_DONE, S_ERR
  } state_t;

  localparam logic [7:0] LP_NAME_MAX = 8'(NAME_MAX);
  localparam logic [7:0] LP_MIN_SYNC = 8'(MIN_SYNC);

  state_t      r_state;
  logic [24:0] r_ptr;
  logic [7:0]  r_sync_cnt;
  logic [3:0]  r_hidx;
  logic [7:0]  r_autorun;
  logic [15:0] r_end;
  logic [15:0] r_start;
  logic [7:0]  r_name_cnt;
  logic [16:0] r_wcnt;
  logic [15:0] r_waddr;
  logic [24:0] r_cache_addr;
  logic        r_cache_rd;
  logic [15:0] r_tape_addr;
  logic        r_tape_wr;
  logic [7:0]  r_tape_dout;
  logic [15:0] r_loadpoint;
  logic        r_tape_autorun;
  logic        r_tape_complete;
  logic        r_error;

  logic [24:0] w_ptr_nx;
  logic        w_underrun;
  logic [16:0] w_count;

`ifdef TAP_FASTLOAD_BASIC_PTR_EN
  logic [7:0]  r_type;
  logic [2:0]  r_pidx;
  logic [15:0] w_end_p1;
  assign w_end_p1 = r_end + 16'd1;
`endif

  assign w_ptr_nx   = r_ptr + 25'd1;
  assign w_underrun = w_ptr_nx > tape_end;
  assign w_count    = {1'b0, r_end} - {1'b0, r_start} + 17'd1;

  always_ff @(posedge clk_48) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_ptr           <= '0;
      r_sync_cnt      <= '0;
      r_hidx          <= '0;
      r_autorun       <= '0;
      r_end           <= '0;
      r_start         <= '0;
      r_name_cnt      <= '0;
      r_wcnt          <= '0;
      r_waddr         <= '0;
      r_cache_addr    <= '0;
      r_cache_rd      <= 1'b0;
      r_tape_addr     <= '0;
      r_tape_wr       <= 1'b0;
      r_tape_dout     <= '0;
      r_loadpoint     <= '0;
      r_tape_autorun  <= 1'b0;
      r_tape_complete <= 1'b0;
      r_error         <= 1'b0;
`ifdef TAP_FASTLOAD_BASIC_PTR_EN
      r_type          <= '0;
      r_pidx          <= '0;
`endif
    end else begin
      r_cache_rd <= 1'b0;
      r_tape_wr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ptr           <= '0;
            r_cache_addr    <= '0;
            r_cache_rd      <= 1'b1;
            r_sync_cnt      <= '0;
            r_tape_complete <= 1'b0;
            r_tape_autorun  <= 1'b0;
            r_error         <= 1'b0;
            r_state         <= S_SYNC;
          end
        end
        S_SYNC, S_HEADER, S_NAME, S_DATA: begin
          // Cycles alternate issue/capture; r_cache_rd low marks a capture cycle.
          if (!r_cache_rd) begin
            r_ptr        <= w_ptr_nx;
            r_cache_addr <= w_ptr_nx;
            if (w_underrun) r_state <= S_ERR;
            else            r_cache_rd <= 1'b1;
            case (r_state)
              S_SYNC: begin
                if (cache_data == 8'h16) begin
                  if (r_sync_cnt != 8'hFF) r_sync_cnt <= r_sync_cnt + 8'd1;
                end else if (cache_data == 8'h24 && r_sync_cnt >= LP_MIN_SYNC) begin
                  r_hidx <= '0;
                  if (!w_underrun) r_state <= S_HEADER;
                end else begin
                  r_cache_rd <= 1'b0;
                  r_state    <= S_ERR;
                end
              end
              S_HEADER: begin
                r_hidx <= r_hidx + 4'd1;
                case (r_hidx)
`ifdef TAP_FASTLOAD_BASIC_PTR_EN
                  4'd2: r_type <= cache_data;
`endif
                  4'd3: r_autorun <= cache_data;
                  4'd4: r_end[15:8] <= cache_data;
                  4'd5: r_end[7:0] <= cache_data;
                  4'd6: r_start[15:8] <= cache_data;
                  4'd7: r_start[7:0] <= cache_data;
                  4'd8: begin
                    if (r_end < r_start) begin
                      r_cache_rd <= 1'b0;
                      r_state    <= S_ERR;
                    end else begin
                      r_loadpoint <= r_start;
                      r_name_cnt  <= '0;
                      if (!w_underrun) r_state <= S_NAME;
                    end
                  end
                  default: ;
                endcase
              end
              S_NAME: begin
                if (cache_data == 8'h00) begin
                  r_wcnt  <= w_count;
                  r_waddr <= r_start;
                  if (!w_underrun) r_state <= S_DATA;
                end else if (r_name_cnt == LP_NAME_MAX) begin
                  r_cache_rd <= 1'b0;
                  r_state    <= S_ERR;
                end else begin
                  r_name_cnt <= r_name_cnt + 8'd1;
                end
              end
              default: begin
                r_tape_wr   <= 1'b1;
                r_tape_addr <= r_waddr;
                r_tape_dout <= cache_data;
                r_waddr     <= r_waddr + 16'd1;
                r_wcnt      <= r_wcnt - 17'd1;
                if (r_wcnt == 17'd1) begin
                  r_cache_rd <= 1'b0;
`ifdef TAP_FASTLOAD_BASIC_PTR_EN
                  r_pidx <= '0;
                  r_state <= (r_type == 8'h00) ? S_PTRS : S_DONE;
`else
                  r_state <= S_DONE;
`endif
                end
              end
            endcase
          end
        end
`ifdef TAP_FASTLOAD_BASIC_PTR_EN
        S_PTRS: begin
          // VARTAB, ARYTAB and STREND all point just past the program.
          r_tape_wr   <= 1'b1;
          r_tape_addr <= 16'h009C + {13'd0, r_pidx};
          r_tape_dout <= r_pidx[0] ? w_end_p1[15:8] : w_end_p1[7:0];
          r_pidx      <= r_pidx + 3'd1;
          if (r_pidx == 3'd5) r_state <= S_DONE;
        end
`endif
        S_DONE: begin
          r_tape_complete <= 1'b1;
          r_tape_autorun  <= (r_autorun != 8'h00);
          r_state         <= S_IDLE;
        end
        S_ERR: begin
          r_error <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cache_addr    = r_cache_addr;
  assign cache_rd      = r_cache_rd;
  assign tape_addr     = r_tape_addr;
  assign tape_wr       = r_tape_wr;
  assign tape_dout     = r_tape_dout;
  assign loadpoint     = r_loadpoint;
  assign tape_autorun  = r_tape_autorun;
  assign tape_complete = r_tape_complete;
  assign busy          = (r_state != S_IDLE);
  assign error         = r_error;

endmodule
